y_row_writer: RTL and testbench
===============================

Name: y_row_writer

Overview:
Write-side counterpart of the Y address decoder. It accepts one updated Y row (two 256-bit lines) with its row number and resolves the row's base line address through the pointer table in Y SRAM. It then writes both lines to consecutive SRAM addresses. Row number 16'hFFFF selects streaming mode, which bypasses the pointer lookup and uses an internal sequential write pointer that advances by 2.

Parameters:
ADDR_W, 11, SRAM line address width
LINE_W, 256, SRAM line width; one row = 2 lines
STREAM_BASE, 64, stream pointer value after reset (first line past the pointer table)

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
yRW_enable  in  1  block enable; low aborts any operation and blocks acceptance
yRW_inValid  in  1  row offered
yRW_inReady  out  1  high when able to accept a row
yRW_rowNum  in  16  row number; 16'hFFFF = stream mode
yRW_rowData  in  512  [255:0] = low line, [511:256] = high line
yRW_memAddr  out  11  SRAM address
yRW_memRdEn  out  1  SRAM read strobe; data is valid on yRW_memRdData the following cycle
yRW_memRdData  in  256  SRAM read data
yRW_memWrEn  out  1  SRAM write strobe
yRW_memWrData  out  256  SRAM write data
yRW_done  out  1  one-cycle pulse: row fully written
yRW_err  out  1  readback mismatch flag (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset values: inReady=0, memAddr=11'h7FF, memRdEn=0, memWrEn=0, memWrData=0, done=0, err=0, stream pointer=STREAM_BASE, state=IDLE.
- IDLE:
  - inReady = enable.
  - A transfer is accepted when inValid & inReady are both high at a clock edge.
  - On acceptance, rowNum and rowData are captured. Later changes to the inputs are ignored.
- Lookup path (rowNum != 16'hFFFF), with acceptance in cycle N:
  - N+1 PTR_RD: memRdEn=1, memAddr=rowNum[14:4]. rowNum[15] is ignored.
  - N+2 PTR_WAIT: sample memRdData. Entry = memRdData[rowNum[3:0]*16 +: 16]. Base = entry[10:0]; entry[15:11] is ignored.
  - N+3 WR_LO: memWrEn=1, memAddr=base, memWrData=rowData[255:0].
  - N+4 WR_HI: memWrEn=1, memAddr=base+1 (mod 2^11; 11'h7FF wraps to 11'h000), memWrData=rowData[511:256]. done=1.
  - N+5 IDLE: inReady=1 if enable is high.
- Stream path (rowNum == 16'hFFFF), with acceptance in cycle N:
  - N+1 WR_LO: address = stream pointer.
  - N+2 WR_HI: address = stream pointer + 1; done=1. The stream pointer then advances by 2 (mod 2^11).
  - No read is issued on this path.
- Strobes: memRdEn and memWrEn are never high in the same cycle. Both are 0 in IDLE. memAddr holds its last value when idle.
- Abort: enable low in any cycle makes the next state IDLE.
  - No further strobes are issued and done is not pulsed.
  - A write already issued is not undone.
  - The stream pointer advances only if WR_HI completed.
- Reset mid-operation: immediate return to reset values in the next cycle, stream pointer included.
- Simultaneous events:
  - reset has priority over enable.
  - inValid during a busy state is ignored, because inReady=0.
  - The cycle after done, inReady rises; back-to-back acceptance is allowed in that cycle.

Optional Feature:
- Macro: YRW_READBACK_CHECK_EN.
- When defined, WR_HI is followed by three states and done moves to RB_CMP:
  - RB_LO: memRdEn=1, address = base.
  - RB_HI: memRdEn=1, address = base+1; compare the low line.
  - RB_CMP: compare the high line.
- err is sticky: it is set on any mismatch and cleared only by reset.
- Lookup-path latency becomes N+7 to done; stream-path latency becomes N+5.
- When not defined, err is tied 0 and timing is as in Behaviour.

Test Plan:
1. Lookup write. Pointer line 0x012, entry 5 = 16'h0100. Accept rowNum=16'h0125, rowData={256'hB…,256'hA…}. Required: read at 0x012 in N+1; write A@0x100 in N+3; write B@0x101 in N+4; done in N+4.
2. Stream mode. Two rows with rowNum=16'hFFFF, accepted back-to-back after reset. Required: writes at 0x040/0x041, then 0x042/0x043; one done per row.
3. Address wrap. Pointer entry = 16'h07FF. Required: low line written @0x7FF, high line @0x000.
4. Abort. Deassert enable in the PTR_WAIT cycle. Required: no memWrEn, no done; IDLE next cycle; inReady=0 until enable returns, then inReady=1.
5. Reset mid-stream. Assert reset in a stream-path WR_LO. Required: all outputs at reset values next cycle; the next stream row writes @0x040.
6. With YRW_READBACK_CHECK_EN. Model the SRAM to corrupt bit 0 of the high line. Required: err=1 in the cycle after RB_CMP and remains 1 through later good rows.

Source files
------------

// File: rtl/y_row_writer.sv
// y_row_writer
// ------------
// Write side of the Y row store. A row of two 256-bit lines is accepted with its
// row number. The row's base line address is found through the pointer table in
// Y SRAM, and the two lines are then written to base and base+1. Row number
// 16'hFFFF selects streaming mode, which skips the lookup and writes at an
// internal pointer that advances by two lines per completed row.
//
// Optional feature macro: YRW_READBACK_CHECK_EN
//   When defined, each row is read back after it is written and compared.
//   Any mismatch sets the sticky err flag. When undefined, err stays 0.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   yRW_enable        block enable; low aborts the current row
//   yRW_inValid/Ready row handshake; yRW_rowNum / yRW_rowData carry the row
//   yRW_memAddr       SRAM line address
//   yRW_memRdEn       read strobe; yRW_memRdData is valid the next cycle
//   yRW_memWrEn       write strobe with yRW_memWrData
//   yRW_done          one-cycle pulse when a row is complete
//   yRW_err           sticky readback mismatch flag
module y_row_writer #(
    parameter int ADDR_W      = 11,
    parameter int LINE_W      = 256,
    parameter int STREAM_BASE = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                yRW_enable,
    input  logic                yRW_inValid,
    output logic                yRW_inReady,
    input  logic [15:0]         yRW_rowNum,
    input  logic [2*LINE_W-1:0] yRW_rowData,
    output logic [ADDR_W-1:0]   yRW_memAddr,
    output logic                yRW_memRdEn,
    input  logic [LINE_W-1:0]   yRW_memRdData,
    output logic                yRW_memWrEn,
    output logic [LINE_W-1:0]   yRW_memWrData,
    output logic                yRW_done,
    output logic                yRW_err
);

    typedef enum logic [2:0] {
        IDLE,
        PTR_RD,
        PTR_WAIT,
        WR_LO,
        WR_HI,
        RB_LO,
        RB_HI,
        RB_CMP
    } state_t;

    state_t                state;
    logic [3:0]            row_idx;
    logic [2*LINE_W-1:0]   row_data;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     stream_ptr;
    logic                  is_stream;
    logic                  stream_req;
    logic [ADDR_W-1:0]     ptr_base;

    assign stream_req = (yRW_rowNum == 16'hFFFF);

    // Each pointer line holds 16 entries of 16 bits; only the low ADDR_W bits
    // of the selected entry form the base address.
    assign ptr_base = yRW_memRdData[{row_idx, 4'b0000} +: ADDR_W];

    // Single sequencer: every output is a register updated here. Enable low
    // forces IDLE and silences strobes without touching the stream pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            yRW_inReady   <= 1'b0;
            yRW_memAddr   <= '1;
            yRW_memRdEn   <= 1'b0;
            yRW_memWrEn   <= 1'b0;
            yRW_memWrData <= '0;
            yRW_done      <= 1'b0;
            yRW_err       <= 1'b0;
            stream_ptr    <= ADDR_W'(STREAM_BASE);
            row_idx       <= '0;
            row_data      <= '0;
            base_addr     <= '0;
            is_stream     <= 1'b0;
        end else if (!yRW_enable) begin
            state       <= IDLE;
            yRW_inReady <= 1'b0;
            yRW_memRdEn <= 1'b0;
            yRW_memWrEn <= 1'b0;
            yRW_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    yRW_memRdEn <= 1'b0;
                    yRW_memWrEn <= 1'b0;
                    yRW_done    <= 1'b0;
                    if (yRW_inValid && yRW_inReady) begin
                        yRW_inReady <= 1'b0;
                        row_idx     <= yRW_rowNum[3:0];
                        row_data    <= yRW_rowData;
                        is_stream   <= stream_req;
                        if (stream_req) begin
                            base_addr     <= stream_ptr;
                            yRW_memWrEn   <= 1'b1;
                            yRW_memAddr   <= stream_ptr;
                            yRW_memWrData <= yRW_rowData[LINE_W-1:0];
                            state         <= WR_LO;
                        end else begin
                            yRW_memRdEn <= 1'b1;
                            yRW_memAddr <= yRW_rowNum[ADDR_W+3:4];
                            state       <= PTR_RD;
                        end
                    end else begin
                        yRW_inReady <= 1'b1;
                    end
                end
                PTR_RD: begin
                    yRW_memRdEn <= 1'b0;
                    state       <= PTR_WAIT;
                end
                PTR_WAIT: begin
                    base_addr     <= ptr_base;
                    yRW_memWrEn   <= 1'b1;
                    yRW_memAddr   <= ptr_base;
                    yRW_memWrData <= row_data[LINE_W-1:0];
                    state         <= WR_LO;
                end
                WR_LO: begin
                    yRW_memAddr   <= base_addr + ADDR_W'(1);
                    yRW_memWrData <= row_data[2*LINE_W-1:LINE_W];
`ifdef YRW_READBACK_CHECK_EN
                    yRW_done      <= 1'b0;
`else
                    yRW_done      <= 1'b1;
`endif
                    state         <= WR_HI;
                end
                WR_HI: begin
                    yRW_memWrEn <= 1'b0;
                    yRW_done    <= 1'b0;
                    if (is_stream) begin
                        stream_ptr <= stream_ptr + ADDR_W'(2);
                    end
`ifdef YRW_READBACK_CHECK_EN
                    yRW_memRdEn <= 1'b1;
                    yRW_memAddr <= base_addr;
                    state       <= RB_LO;
`else
                    yRW_inReady <= 1'b1;
                    state       <= IDLE;
`endif
                end
`ifdef YRW_READBACK_CHECK_EN
                RB_LO: begin
                    yRW_memAddr <= base_addr + ADDR_W'(1);
                    state       <= RB_HI;
                end
                // Low line read in RB_LO is on the read bus now.
                RB_HI: begin
                    yRW_memRdEn <= 1'b0;
                    yRW_done    <= 1'b1;
                    if (yRW_memRdData != row_data[LINE_W-1:0]) begin
                        yRW_err <= 1'b1;
                    end
                    state <= RB_CMP;
                end
                RB_CMP: begin
                    yRW_done    <= 1'b0;
                    yRW_inReady <= 1'b1;
                    if (yRW_memRdData != row_data[2*LINE_W-1:LINE_W]) begin
                        yRW_err <= 1'b1;
                    end
                    state <= IDLE;
                end
`endif
                default: begin
                    yRW_memRdEn <= 1'b0;
                    yRW_memWrEn <= 1'b0;
                    yRW_done    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_row_writer.sv
// Testbench for y_row_writer: SRAM model plus scoreboard of expected reads,
// writes and done pulses (address, data and cycle), pushed when a row is
// offered and popped by a monitor as the DUT strobes.
module tb_y_row_writer;

`ifdef YRW_READBACK_CHECK_EN
    localparam int RB = 3;
`else
    localparam int RB = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         yRW_enable = 1'b1;
    logic         yRW_inValid = 1'b0;
    logic         yRW_inReady;
    logic [15:0]  yRW_rowNum = 16'h0;
    logic [511:0] yRW_rowData = '0;
    logic [10:0]  yRW_memAddr;
    logic         yRW_memRdEn;
    logic [255:0] yRW_memRdData;
    logic         yRW_memWrEn;
    logic [255:0] yRW_memWrData;
    logic         yRW_done;
    logic         yRW_err;

    y_row_writer dut (
        .clock         (clock),
        .reset         (reset),
        .yRW_enable    (yRW_enable),
        .yRW_inValid   (yRW_inValid),
        .yRW_inReady   (yRW_inReady),
        .yRW_rowNum    (yRW_rowNum),
        .yRW_rowData   (yRW_rowData),
        .yRW_memAddr   (yRW_memAddr),
        .yRW_memRdEn   (yRW_memRdEn),
        .yRW_memRdData (yRW_memRdData),
        .yRW_memWrEn   (yRW_memWrEn),
        .yRW_memWrData (yRW_memWrData),
        .yRW_done      (yRW_done),
        .yRW_err       (yRW_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [10:0]  addr;
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   dq[$];

    int total = 0;
    int bad = 0;

    // SRAM model with one-cycle read latency and an optional corrupted line.
    logic [255:0] mem [0:2047];
    logic [255:0] rd_q = '0;
    logic         corrupt_en = 1'b0;
    logic [10:0]  corrupt_addr = '0;
    assign yRW_memRdData = rd_q;

    always @(posedge clock) begin
        if (yRW_memWrEn) mem[yRW_memAddr] <= yRW_memWrData;
        if (yRW_memRdEn)
            rd_q <= mem[yRW_memAddr] ^ ((corrupt_en && yRW_memAddr == corrupt_addr) ? 256'd1 : 256'd0);
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (yRW_memRdEn && yRW_memWrEn) checkOutput("strobe_excl", yRW_memRdEn & yRW_memWrEn, 0);
        if (yRW_memWrEn) begin
            if (wq.size() == 0) checkOutput("wr_extra", yRW_memWrEn, 0);
            else begin
                e = wq.pop_front();
                checkOutput("wr_addr", yRW_memAddr, e.addr);
                checkOutput("wr_data", yRW_memWrData, e.data);
                checkOutput("wr_cyc", cyc, e.cyc);
            end
        end
        if (yRW_memRdEn) begin
            if (rq.size() == 0) checkOutput("rd_extra", yRW_memRdEn, 0);
            else begin
                e = rq.pop_front();
                checkOutput("rd_addr", yRW_memAddr, e.addr);
                checkOutput("rd_cyc", cyc, e.cyc);
            end
        end
        if (yRW_done) begin
            if (dq.size() == 0) checkOutput("done_extra", yRW_done, 0);
            else checkOutput("done_cyc", cyc, dq.pop_front());
        end
    end

    function automatic logic [255:0] randLine();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic exp_t mk(input logic [10:0] a, input logic [255:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    // Offer one row; push what it should produce. full=0 pushes only the first
    // access (for rows that get aborted or reset). Returns the acceptance cycle.
    task automatic applyStimulus(input logic [15:0] rn, input logic [511:0] data,
                                 input logic [10:0] base, input bit full, output int acc);
        int waited = 0;
        bit strm;
        acc = -1;
        strm = (rn == 16'hFFFF);
        @(negedge clock);
        while (yRW_inReady !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (yRW_inReady !== 1'b1) begin
            checkOutput("ready_timeout", yRW_inReady, 1);
            return;
        end
        acc = cyc;
        if (strm) begin
            wq.push_back(mk(base, data[255:0], acc + 1));
            if (full) begin
                wq.push_back(mk(base + 11'd1, data[511:256], acc + 2));
                if (RB != 0) begin
                    rq.push_back(mk(base, '0, acc + 3));
                    rq.push_back(mk(base + 11'd1, '0, acc + 4));
                end
                dq.push_back(acc + 2 + RB);
            end
        end else begin
            rq.push_back(mk(rn[14:4], '0, acc + 1));
            if (full) begin
                wq.push_back(mk(base, data[255:0], acc + 3));
                wq.push_back(mk(base + 11'd1, data[511:256], acc + 4));
                if (RB != 0) begin
                    rq.push_back(mk(base, '0, acc + 5));
                    rq.push_back(mk(base + 11'd1, '0, acc + 6));
                end
                dq.push_back(acc + 4 + RB);
            end
        end
        yRW_rowNum  = rn;
        yRW_rowData = data;
        yRW_inValid = 1'b1;
        @(posedge clock);
        #1;
        yRW_inValid = 1'b0;
        yRW_rowNum  = 16'h1234;
        yRW_rowData = {randLine(), randLine()};
    endtask

    task automatic waitDrain(input string tag);
        int w = 0;
        while ((wq.size() + rq.size() + dq.size()) != 0 && w < 60) begin
            @(negedge clock);
            w++;
        end
        checkOutput(tag, wq.size() + rq.size() + dq.size(), 0);
        wq.delete();
        rq.delete();
        dq.delete();
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_inReady"}, yRW_inReady, 0);
        checkOutput({tag, "_memAddr"}, yRW_memAddr, 11'h7FF);
        checkOutput({tag, "_memRdEn"}, yRW_memRdEn, 0);
        checkOutput({tag, "_memWrEn"}, yRW_memWrEn, 0);
        checkOutput({tag, "_memWrData"}, yRW_memWrData, 0);
        checkOutput({tag, "_done"}, yRW_done, 0);
        checkOutput({tag, "_err"}, yRW_err, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc1, acc2;
        logic [10:0] model_ptr;
        logic [255:0] lineA, lineB;

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h012][5*16 +: 16] = 16'h0100;
        mem[11'h012][6*16 +: 16] = 16'hF9AB;
        mem[11'h020][3*16 +: 16] = 16'h07FF;
        model_ptr = 11'h040;

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetValues("reset");
        reset = 1'b0;

        // Stream mode, two rows back-to-back after reset.
        applyStimulus(16'hFFFF, {randLine(), randLine()}, model_ptr, 1, acc1);
        model_ptr = model_ptr + 11'd2;
        applyStimulus(16'hFFFF, {randLine(), randLine()}, model_ptr, 1, acc2);
        model_ptr = model_ptr + 11'd2;
        checkOutput("b2b_gap", acc2 - acc1, 3 + RB);
        waitDrain("drain_stream");

        // Lookup write through pointer line 0x012 entry 5.
        lineA = {32{8'hAA}};
        lineB = {32{8'hBB}};
        applyStimulus(16'h0125, {lineB, lineA}, 11'h100, 1, acc1);
        waitDrain("drain_lookup");

        // Row number bit 15 and entry bits [15:11] must be ignored.
        applyStimulus(16'h8125, {randLine(), randLine()}, 11'h100, 1, acc1);
        applyStimulus(16'h0126, {randLine(), randLine()}, 11'h1AB, 1, acc1);
        waitDrain("drain_ignore");

        // Base 0x7FF: high line wraps to 0x000.
        applyStimulus(16'h0203, {randLine(), randLine()}, 11'h7FF, 1, acc1);
        waitDrain("drain_wrap");

        // Abort in PTR_WAIT: no writes, no done, inReady low until enable returns.
        applyStimulus(16'h0125, {randLine(), randLine()}, 11'h100, 0, acc1);
        @(posedge clock);
        #1;
        yRW_enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("abort_ready_low", yRW_inReady, 0);
        end
        @(posedge clock);
        #1;
        yRW_enable = 1'b1;
        @(negedge clock);
        checkOutput("abort_ready_still_low", yRW_inReady, 0);
        @(negedge clock);
        checkOutput("abort_ready_back", yRW_inReady, 1);
        waitDrain("drain_abort");

        // Reset during a stream WR_LO; pointer returns to its base.
        applyStimulus(16'hFFFF, {randLine(), randLine()}, model_ptr, 0, acc1);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkResetValues("midreset");
        reset = 1'b0;
        wq.delete();
        model_ptr = 11'h040;
        applyStimulus(16'hFFFF, {randLine(), randLine()}, model_ptr, 1, acc1);
        model_ptr = model_ptr + 11'd2;
        waitDrain("drain_after_reset");

`ifdef YRW_READBACK_CHECK_EN
        // Corrupt bit 0 of the high line on readback; err must set and stick.
        corrupt_en   = 1'b1;
        corrupt_addr = model_ptr + 11'd1;
        applyStimulus(16'hFFFF, {randLine(), randLine()}, model_ptr, 1, acc1);
        model_ptr = model_ptr + 11'd2;
        while (cyc < acc1 + 5) @(negedge clock);
        checkOutput("err_before", yRW_err, 0);
        @(negedge clock);
        checkOutput("err_set", yRW_err, 1);
        waitDrain("drain_rb_bad");
        corrupt_en = 1'b0;
        applyStimulus(16'h0125, {randLine(), randLine()}, 11'h100, 1, acc1);
        waitDrain("drain_rb_good");
        checkOutput("err_sticky", yRW_err, 1);
`else
        checkOutput("err_tied", yRW_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
